decoder_nto2n_reg: RTL and testbench

DECODER_NTO2N_REG -- requirements
Module: decoder_nto2n_reg

---
 rtl/decoder_nto2n_reg.sv | 57 +++++
 tb/tb_decoder_nto2n_reg.sv | 123 ++++++++++++
 2 files changed

// File: rtl/decoder_nto2n_reg.sv
// decoder_nto2n_reg: registered N-to-2**N decoder with handshake input, timed scan and hold modes.
module decoder_nto2n_reg #(
   parameter int N          = 2,
   parameter int SCAN_DIV   = 4,
   parameter int ACTIVE_LOW = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [1:0]        mode,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [N-1:0]      in,
   output logic [2**N-1:0]   out,
   output logic              out_valid,
   output logic              scan_wrap
);
   localparam int W = 2**N;
   localparam int PW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
   localparam logic [PW-1:0] PMAX = PW'(SCAN_DIV - 1);
   logic [N-1:0] idx;
   logic active;
   logic [PW-1:0] psc;
   logic step;
   logic [W-1:0] onehot;
   assign in_ready = en && mode == 2'b00;
   assign step = en && mode == 2'b01 && psc == PMAX;
   assign onehot = active ? W'(1) << idx : '0;
   assign out = ACTIVE_LOW != 0 ? ~onehot : onehot;
   // Any non-scan cycle restarts the prescaler; en=0 freezes it instead.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx <= '0;
         active <= 1'b0;
         psc <= '0;
         out_valid <= 1'b0;
         scan_wrap <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         scan_wrap <= 1'b0;
         if (en) begin
            psc <= mode == 2'b01 ? (psc == PMAX ? '0 : psc + 1'b1) : '0;
            if (in_valid && in_ready) begin
               idx <= in;
               active <= 1'b1;
               out_valid <= 1'b1;
            end else if (step) begin
               active <= 1'b1;
               if (active) begin
                  idx <= idx + 1'b1;
                  scan_wrap <= &idx;
               end
            end
         end
      end
   end
endmodule

// File: tb/tb_decoder_nto2n_reg.sv
// tb_decoder_nto2n_reg: two decoder configurations driven by directed and random stimulus against a position/tick model.
module tb_decoder_nto2n_reg;
   logic clk = 1'b0, rst = 1'b1, en = 1'b0, in_valid = 1'b0;
   logic [1:0] mode = 2'b00, in0 = '0;
   logic [2:0] in1 = '0;
   logic rdy0, rdy1, ov0, ov1, wr0, wr1;
   logic [3:0] out0;
   logic [7:0] out1;
   int checks = 0, errors = 0;
   int pos[2], tick[2], ov[2], wr[2];
   int nb[2] = '{2, 3};
   int dv[2] = '{4, 1};

   always #5 clk = ~clk;

   decoder_nto2n_reg #(.N(2), .SCAN_DIV(4), .ACTIVE_LOW(0)) d0 (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .in_valid(in_valid), .in_ready(rdy0),
      .in(in0), .out(out0), .out_valid(ov0), .scan_wrap(wr0));
   decoder_nto2n_reg #(.N(3), .SCAN_DIV(1), .ACTIVE_LOW(1)) d1 (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .in_valid(in_valid), .in_ready(rdy1),
      .in(in1), .out(out1), .out_valid(ov1), .scan_wrap(wr1));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
      end
   endtask

   // Active position -1 means nothing lit; DUT 1 drives its 8 outputs active-low.
   function automatic logic [31:0] exp_out(input int k);
      logic [31:0] v;
      v = pos[k] < 0 ? 32'd0 : 32'd1 << pos[k];
      return k == 1 ? (~v & 32'hff) : v;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         pos[k] = -1; tick[k] = 0; ov[k] = 0; wr[k] = 0;
      end
   endtask

   task automatic model_step();
      for (int k = 0; k < 2; k++) begin
         int sel, size;
         sel = k == 1 ? int'(in1) : int'(in0);
         size = 1 << nb[k];
         ov[k] = 0; wr[k] = 0;
         if (en) begin
            if (mode == 2'b01) begin
               tick[k]++;
               if (tick[k] == dv[k]) begin
                  tick[k] = 0;
                  if (pos[k] < 0) pos[k] = 0;
                  else begin
                     wr[k] = pos[k] == size - 1;
                     pos[k] = (pos[k] + 1) % size;
                  end
               end
            end else begin
               tick[k] = 0;
               if (mode == 2'b00 && in_valid) begin
                  pos[k] = sel; ov[k] = 1;
               end
            end
         end
      end
   endtask

   task automatic check_outs();
      check("out0", 32'(out0), exp_out(0));
      check("out_valid0", 32'(ov0), ov[0]);
      check("scan_wrap0", 32'(wr0), wr[0]);
      check("out1", 32'(out1), exp_out(1));
      check("out_valid1", 32'(ov1), ov[1]);
      check("scan_wrap1", 32'(wr1), wr[1]);
   endtask

   task automatic cyc(input logic e, input logic [1:0] m, input logic v, input logic [2:0] i);
      en = e; mode = m; in_valid = v; in0 = i[1:0]; in1 = i;
      #1;
      check("in_ready0", 32'(rdy0), 32'(e && m == 2'b00));
      check("in_ready1", 32'(rdy1), 32'(e && m == 2'b00));
      model_step();
      @(negedge clk);
      check_outs();
   endtask

   task automatic areset();
      #2 rst = 1'b1;
      #1 model_reset();
      check_outs();
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      model_reset();
      #1 check_outs();
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) cyc(1'b1, 2'b00, 1'b1, 3'(i));
      repeat (10) cyc(1'b1, 2'b10, 1'b1, 3'd6);
      repeat (9) cyc(1'b1, 2'b01, 1'b0, 3'd0);
      cyc(1'b1, 2'b00, 1'b1, 3'd5);
      repeat (10) cyc(1'b1, 2'b10, 1'b0, 3'd0);
      repeat (4) cyc(1'b1, 2'b01, 1'b0, 3'd0);
      areset();
      repeat (22) cyc(1'b1, 2'b01, 1'b0, 3'd0);
      repeat (7) cyc(1'b0, 2'b01, 1'b1, 3'($urandom));
      repeat (10) cyc(1'b1, 2'b01, 1'b0, 3'd0);
      cyc(1'b1, 2'b00, 1'b1, 3'd5);
      repeat (6) cyc(1'b1, 2'b01, 1'b0, 3'd0);
      cyc(1'b1, 2'b11, 1'b1, 3'd2);
      for (int n = 0; n < 500; n++) begin
         if ($urandom_range(0, 59) == 0) areset();
         cyc(1'($urandom_range(0, 7) != 0), 2'($urandom), 1'($urandom), 3'($urandom));
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
